// File: rtl/csr_regfile_pkg.sv
// Shared CSR addresses, field positions, software-writable masks and exception codes
// used by the CSR register file and its timer.
package csr_regfile_pkg;

  localparam int CSR_ADDR_W = 14;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam int CRMD_IE      = 2;
  localparam int ESTAT_IS_TI  = 11;
  localparam int ESTAT_IS_IPI = 12;
  localparam int TCFG_EN      = 0;
  localparam int TCFG_PERIOD  = 1;

  localparam logic [8:0]  CRMD_RESET  = 9'h008;
  localparam logic [12:0] ECFG_WMASK  = 13'h1BFF;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  function automatic logic [31:0] mask_write(input logic [31:0] old_val,
                                             input logic [31:0] wval,
                                             input logic [31:0] wmask);
    return (old_val & ~wmask) | (wval & wmask);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Constant timer: down-counter loaded from TCFG.InitVal, raises a one-cycle
// ti_set request whenever the enabled counter sits at zero.
module csr_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tcfg_we,
  input  logic        tcfg_wr_en,
  input  logic [29:0] tcfg_wr_init,
  input  logic        tcfg_en,
  input  logic        tcfg_periodic,
  input  logic [29:0] tcfg_init,
  output logic [31:0] tval,
  output logic        ti_set
);

  logic [31:0] cnt;

  assign tval   = cnt;
  assign ti_set = tcfg_en & (cnt == 32'h0);

  // All-ones is the parked value: a one-shot timer wraps into it and stops there.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= 32'hFFFF_FFFF;
    end else if (tcfg_we && tcfg_wr_en) begin
      cnt <= {tcfg_wr_init, 2'b00};
    end else if (tcfg_en && (cnt != 32'hFFFF_FFFF)) begin
      if ((cnt == 32'h0) && tcfg_periodic)
        cnt <= {tcfg_init, 2'b00};
      else
        cnt <= cnt - 32'd1;
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// WB-stage CSR responder: architectural control/status registers, exception
// entry / ertn commit, interrupt sampling and the constant timer.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] TID_INIT  = 32'h0,
  parameter int          CSR_NUM_W = 14
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 csr_re,
  input  logic [CSR_NUM_W-1:0] csr_num,
  output logic [31:0]          csr_rvalue,
  input  logic                 csr_we,
  input  logic [31:0]          csr_wmask,
  input  logic [31:0]          csr_wvalue,
  input  logic                 wb_ex,
  input  logic [31:0]          wb_csr_pc,
  input  logic [5:0]           wb_ecode,
  input  logic [8:0]           wb_esubcode,
  input  logic                 ertn_flush,
  input  logic [7:0]           hw_int_in,
  input  logic                 ipi_int_in,
  output logic [31:0]          ex_entry,
  output logic [31:0]          ertn_entry,
  output logic                 has_int
);

  logic [8:0]  crmd;
  logic [2:0]  prmd;
  logic [12:0] ecfg_lie;
  logic [12:0] estat_is;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esub;
  logic [31:0] era;
  logic [25:0] eentry_va;
  logic [31:0] save0, save1, save2, save3;
  logic [31:0] tid;
  logic [31:0] tcfg;

  logic [31:0] rd_raw;
  logic [31:0] wr_merged;
  logic        sw_we;
  logic        tcfg_we;
  logic        ticlr;
  logic [31:0] tval;
  logic        ti_set;

  always_comb begin
    rd_raw = 32'h0;
    case (csr_num)
      CSR_CRMD:   rd_raw = {23'b0, crmd};
      CSR_PRMD:   rd_raw = {29'b0, prmd};
      CSR_ECFG:   rd_raw = {19'b0, ecfg_lie};
      CSR_ESTAT:  rd_raw = {1'b0, estat_esub, estat_ecode, 3'b0, estat_is};
      CSR_ERA:    rd_raw = era;
      CSR_EENTRY: rd_raw = {eentry_va, 6'b0};
      CSR_SAVE0:  rd_raw = save0;
      CSR_SAVE1:  rd_raw = save1;
      CSR_SAVE2:  rd_raw = save2;
      CSR_SAVE3:  rd_raw = save3;
      CSR_TID:    rd_raw = tid;
      CSR_TCFG:   rd_raw = tcfg;
      CSR_TVAL:   rd_raw = tval;
      default:    rd_raw = 32'h0;
    endcase
  end

  assign csr_rvalue = csr_re ? rd_raw : 32'h0;

  // Exception entry and ertn both outrank a software write in the same cycle.
  assign sw_we     = csr_we & ~wb_ex & ~ertn_flush;
  assign wr_merged = mask_write(rd_raw, csr_wvalue, csr_wmask);
  assign tcfg_we   = sw_we & (csr_num == CSR_TCFG);
  assign ticlr     = sw_we & (csr_num == CSR_TICLR) & wr_merged[0];

  csr_timer u_timer (
    .clk           (clk),
    .resetn        (resetn),
    .tcfg_we       (tcfg_we),
    .tcfg_wr_en    (wr_merged[TCFG_EN]),
    .tcfg_wr_init  (wr_merged[31:2]),
    .tcfg_en       (tcfg[TCFG_EN]),
    .tcfg_periodic (tcfg[TCFG_PERIOD]),
    .tcfg_init     (tcfg[31:2]),
    .tval          (tval),
    .ti_set        (ti_set)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd        <= CRMD_RESET;
      prmd        <= 3'b0;
      ecfg_lie    <= 13'b0;
      estat_is    <= 13'b0;
      estat_ecode <= 6'b0;
      estat_esub  <= 9'b0;
      era         <= 32'h0;
      eentry_va   <= 26'b0;
      save0       <= 32'h0;
      save1       <= 32'h0;
      save2       <= 32'h0;
      save3       <= 32'h0;
      tid         <= TID_INIT;
      tcfg        <= 32'h0;
    end else begin
      estat_is[9:2]        <= hw_int_in;
      estat_is[ESTAT_IS_IPI] <= ipi_int_in;
      // A timer event wins over a simultaneous clear so no tick is lost.
      if (ti_set)
        estat_is[ESTAT_IS_TI] <= 1'b1;
      else if (ticlr)
        estat_is[ESTAT_IS_TI] <= 1'b0;

      if (wb_ex) begin
        prmd        <= crmd[2:0];
        crmd[2:0]   <= 3'b0;
        era         <= wb_csr_pc;
        estat_ecode <= wb_ecode;
        estat_esub  <= wb_esubcode;
      end else if (ertn_flush) begin
        crmd[2:0] <= prmd;
      end else if (sw_we) begin
        case (csr_num)
          CSR_CRMD:   crmd          <= wr_merged[8:0];
          CSR_PRMD:   prmd          <= wr_merged[2:0];
          CSR_ECFG:   ecfg_lie      <= wr_merged[12:0] & ECFG_WMASK;
          CSR_ESTAT:  estat_is[1:0] <= wr_merged[1:0];
          CSR_ERA:    era           <= wr_merged;
          CSR_EENTRY: eentry_va     <= wr_merged[31:6];
          CSR_SAVE0:  save0         <= wr_merged;
          CSR_SAVE1:  save1         <= wr_merged;
          CSR_SAVE2:  save2         <= wr_merged;
          CSR_SAVE3:  save3         <= wr_merged;
          CSR_TID:    tid           <= wr_merged;
          CSR_TCFG:   tcfg          <= wr_merged;
          default:    ;
        endcase
      end
    end
  end

  assign has_int    = crmd[CRMD_IE] & (|(estat_is & ecfg_lie));
  assign ex_entry   = {eentry_va, 6'b0};
  assign ertn_entry = era;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a CSR-image model.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [31:0] wb_csr_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  bit chk_en   = 0;

  csr_regfile dut (
    .clk         (clk),
    .resetn      (resetn),
    .csr_re      (csr_re),
    .csr_num     (csr_num),
    .csr_rvalue  (csr_rvalue),
    .csr_we      (csr_we),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .wb_ex       (wb_ex),
    .wb_csr_pc   (wb_csr_pc),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .ertn_flush  (ertn_flush),
    .hw_int_in   (hw_int_in),
    .ipi_int_in  (ipi_int_in),
    .ex_entry    (ex_entry),
    .ertn_entry  (ertn_entry),
    .has_int     (has_int)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: CSR images keyed by address ----------------
  bit [31:0] m_reg [int];
  bit [31:0] m_cnt;

  function automatic bit [31:0] sw_mask(input int a);
    case (a)
      'h00:    return 32'h0000_01FF;
      'h01:    return 32'h0000_0007;
      'h04:    return 32'h0000_1BFF;
      'h05:    return 32'h0000_0003;
      'h0C:    return 32'hFFFF_FFC0;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic bit [31:0] m_read(input int a);
    if (a == 'h42) return m_cnt;
    if (m_reg.exists(a)) return m_reg[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_has_int();
    bit [31:0] c, e, s;
    c = m_reg[0]; e = m_reg[4]; s = m_reg[5];
    return {31'b0, c[2] & (|(s[12:0] & e[12:0]))};
  endfunction

  task automatic m_reset();
    int addrs[14] = '{'h00, 'h01, 'h04, 'h05, 'h06, 'h0C, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41, 'h41, 'h41};
    m_reg.delete();
    foreach (addrs[i]) m_reg[addrs[i]] = 32'h0;
    m_reg[0] = 32'h8;
    m_cnt = 32'hFFFF_FFFF;
  endtask

  task automatic m_step();
    bit [31:0] nx [int];
    bit [31:0] merged, tcfg, msk;
    int a;
    bit wr, ti;
    nx     = m_reg;
    a      = int'(csr_num);
    tcfg   = m_reg['h41];
    wr     = csr_we && !wb_ex && !ertn_flush;
    merged = (m_read(a) & ~csr_wmask) | (csr_wvalue & csr_wmask);
    ti     = tcfg[0] && (m_cnt == 32'h0);
    nx[5] = (nx[5] & ~32'h0000_13FC) | ({24'b0, hw_int_in} << 2) | ({31'b0, ipi_int_in} << 12);
    if (ti) nx[5] = nx[5] | 32'h800;
    else if (wr && a == 'h44 && merged[0]) nx[5] = nx[5] & ~32'h800;
    if (wb_ex) begin
      nx[1] = m_reg[0] & 32'h7;
      nx[0] = m_reg[0] & ~32'h7;
      nx[6] = wb_csr_pc;
      nx[5] = (nx[5] & ~32'h7FFF_0000) | ({26'b0, wb_ecode} << 16) | ({23'b0, wb_esubcode} << 22);
    end else if (ertn_flush) begin
      nx[0] = (m_reg[0] & ~32'h7) | (m_reg[1] & 32'h7);
    end else if (wr && m_reg.exists(a)) begin
      msk   = sw_mask(a);
      nx[a] = (nx[a] & ~msk) | (merged & msk);
    end
    if (wr && a == 'h41 && merged[0]) m_cnt = merged & ~32'h3;
    else if (tcfg[0] && m_cnt != 32'hFFFF_FFFF)
      m_cnt = (m_cnt == 32'h0 && tcfg[1]) ? (tcfg & ~32'h3) : m_cnt - 32'd1;
    m_reg = nx;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_reset();
    else m_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("rvalue", csr_rvalue, csr_re ? m_read(int'(csr_num)) : 32'h0);
      check("ex_entry", ex_entry, m_reg[12] & 32'hFFFF_FFC0);
      check("ertn_entry", ertn_entry, m_reg[6]);
      check("has_int", {31'b0, has_int}, m_has_int());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    csr_we = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
    csr_we = 1'b1; csr_num = a; csr_wmask = m; csr_wvalue = v;
    cyc();
    csr_we = 1'b0;
  endtask

  task automatic expect_rd(input string nm, input logic [13:0] a, input logic [31:0] m,
                           input logic [31:0] e);
    csr_re = 1'b1; csr_num = a; #1;
    check({nm, "/dut"}, csr_rvalue & m, e);
    check({nm, "/model"}, m_read(int'(a)) & m, e);
  endtask

  task automatic wait_ti(output int n);
    n = 0;
    csr_re = 1'b1; csr_num = 14'h005;
    while (n < 40) begin
      cyc(); n++; #1;
      if (csr_rvalue[11]) break;
    end
  endtask

  function automatic logic [13:0] pick_addr();
    logic [13:0] tbl[15] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h0C, 14'h30, 14'h31,
                             14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h41};
    int k = $urandom_range(0, 15);
    if (k == 15) return 14'($urandom());
    return tbl[k];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, t_prev, t_now;
    csr_re = 1'b0; csr_num = 14'h0; csr_we = 1'b0; csr_wmask = 32'h0; csr_wvalue = 32'h0;
    wb_ex = 1'b0; wb_csr_pc = 32'h0; wb_ecode = 6'h0; wb_esubcode = 9'h0; ertn_flush = 1'b0;
    hw_int_in = 8'h0; ipi_int_in = 1'b0;
    m_reset();
    cyc(2);
    chk_en = 1;
    cyc(1);
    resetn = 1'b1;

    // reset state
    expect_rd("rst_crmd", 14'h000, 32'hFFFF_FFFF, 32'h8);
    expect_rd("rst_estat", 14'h005, 32'hFFFF_FFFF, 32'h0);
    expect_rd("rst_tval", 14'h042, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("rst_ex_entry", ex_entry, 32'h0);
    check("rst_has_int", {31'b0, has_int}, 32'h0);
    csr_re = 1'b0; csr_num = 14'h000; #1;
    check("re_low_zero", csr_rvalue, 32'h0);

    // exception entry / return
    wr(14'h000, 32'h7, 32'h7);
    expect_rd("crmd_wr", 14'h000, 32'hFFFF_FFFF, 32'hF);
    wb_ex = 1'b1; wb_csr_pc = 32'h1C00_0100; wb_ecode = 6'hB; wb_esubcode = 9'h0;
    cyc(); wb_ex = 1'b0;
    expect_rd("ex_prmd", 14'h001, 32'hFFFF_FFFF, 32'h7);
    expect_rd("ex_crmd", 14'h000, 32'hFFFF_FFFF, 32'h8);
    expect_rd("ex_era", 14'h006, 32'hFFFF_FFFF, 32'h1C00_0100);
    expect_rd("ex_ecode", 14'h005, 32'h003F_0000, 32'h000B_0000);
    check("ex_ertn_entry", ertn_entry, 32'h1C00_0100);
    ertn_flush = 1'b1; cyc(); ertn_flush = 1'b0;
    expect_rd("ertn_crmd", 14'h000, 32'hFFFF_FFFF, 32'hF);

    // exception beats a same-cycle write
    wb_ex = 1'b1; wb_csr_pc = 32'h1C00_0200; wb_ecode = 6'h8; wb_esubcode = 9'h1;
    csr_we = 1'b1; csr_num = 14'h030; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'hDEAD_BEEF;
    cyc(); idle();
    expect_rd("exwe_save0", 14'h030, 32'hFFFF_FFFF, 32'h0);
    expect_rd("exwe_era", 14'h006, 32'hFFFF_FFFF, 32'h1C00_0200);
    expect_rd("exwe_estat", 14'h005, 32'h7FFF_0000, 32'h0048_0000);
    expect_rd("exwe_prmd", 14'h001, 32'hFFFF_FFFF, 32'h7);

    // one-shot timer
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0011);
    wait_ti(n);
    check("oneshot_delay", 32'(n), 32'd17);
    expect_rd("oneshot_tval", 14'h042, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc(3);
    expect_rd("oneshot_tval_hold", 14'h042, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(14'h044, 32'h1, 32'h1);
    expect_rd("ticlr", 14'h005, 32'h800, 32'h0);

    // periodic timer, three periods
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0013);
    t_prev = cyc_n;
    for (int p = 0; p < 3; p++) begin
      wait_ti(n);
      t_now = cyc_n;
      check("periodic_gap", 32'(t_now - t_prev), 32'd17);
      t_prev = t_now;
      wr(14'h044, 32'h1, 32'h1);
    end
    wr(14'h041, 32'hFFFF_FFFF, 32'h0);

    // interrupt path
    wr(14'h004, 32'hFFFF_FFFF, 32'h4);
    wr(14'h000, 32'h4, 32'h4);
    hw_int_in = 8'h01;
    cyc(); #1;
    check("has_int_on", {31'b0, has_int}, 32'h1);
    wr(14'h000, 32'h4, 32'h0); #1;
    check("has_int_ie_off", {31'b0, has_int}, 32'h0);
    hw_int_in = 8'h00;
    cyc();
    expect_rd("is2_clear", 14'h005, 32'h4, 32'h0);

    // randomized traffic, with one asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      idle();
      csr_re      = ($urandom_range(0, 3) != 0);
      csr_num     = pick_addr();
      csr_we      = ($urandom_range(0, 2) == 0);
      csr_wmask   = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom();
      csr_wvalue  = $urandom();
      if (csr_num == 14'h041) begin
        csr_wmask  = 32'hFFFF_FFFF;
        csr_wvalue = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      end
      wb_ex       = ($urandom_range(0, 15) == 0);
      ertn_flush  = ($urandom_range(0, 15) == 0);
      wb_csr_pc   = $urandom();
      wb_ecode    = 6'($urandom());
      wb_esubcode = 9'($urandom());
      if ($urandom_range(0, 3) == 0) hw_int_in = 8'($urandom());
      if ($urandom_range(0, 7) == 0) ipi_int_in = 1'($urandom());
      if (i == 1500) begin
        #1 resetn = 1'b0;
        csr_re = 1'b1; csr_num = 14'h042; #1;
        check("midrst_tval", csr_rvalue, 32'hFFFF_FFFF);
        csr_num = 14'h000; #1;
        check("midrst_crmd", csr_rvalue, 32'h8);
        cyc(2);
        resetn = 1'b1;
      end else begin
        cyc();
      end
    end

    idle();
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
